vga_scanout: RTL and testbench
==============================

# vga_scanout

Scanout stage directly upstream of the frame-buffer `bram`. It generates 640x480 @ 60 Hz VGA timing, issues one read per active pixel to the frame buffer (a 160x120 image upscaled 4x by pixel replication), and registers the returned pixel word onto the RGB pins. HSYNC and VSYNC are delayed to stay aligned with the one-cycle BRAM read latency.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP` / `H_SYNC` / `H_BP`, 16 / 96 / 48, horizontal porch and sync widths (line total 800)
- `V_ACTIVE`, 480, visible lines
- `V_FP` / `V_SYNC` / `V_BP`, 10 / 2 / 33, vertical porch and sync widths (frame total 525)
- `SCALE_SHIFT`, 2, log2 of the upscale factor; image is `H_ACTIVE>>SCALE_SHIFT` by `V_ACTIVE>>SCALE_SHIFT`
- `SYNC_POL`, 0, asserted level of both sync outputs
- `RAM_ADDR_BITS`, 15, frame-buffer address width
- `RAM_WIDTH`, 12, pixel word width, packed as {R[11:8], G[7:4], B[3:0]}
- `clock`, in, 1, system clock
- `reset_n`, in, 1, asynchronous active-low reset
- `pixel_enable`, in, 1, single-cycle pixel strobe (e.g. clock/4); all timing advances only on this strobe
- `ram_enable`, out, 1, to bram `ram_enable`
- `address`, out, RAM_ADDR_BITS, to bram `address`
- `ram_data`, in, RAM_WIDTH, from bram `output_data`
- `vga_r`, `vga_g`, `vga_b`, out, 4 each, pixel colour
- `hsync`, `vsync`, out, 1, sync outputs
- `frame_start`, out, 1, one-cycle pulse coinciding with the strobe at which the first output pixel of (0,0) is driven

The block never writes: bram `write_enable` is tied low at the top level.

## Operation
- Counters `h` (0..799) and `v` (0..524) advance only on cycles with `pixel_enable`=1. `h` wraps 799->0 and increments `v`. `v` wraps 524->0.
- Active region: `h<H_ACTIVE && v<V_ACTIVE`.
- Sync timing:
  - hsync asserted for `h` in [656,751]; vsync asserted for `v` in [490,491].
  - Each sync is `SYNC_POL` when asserted and `~SYNC_POL` otherwise.
- Address generation:
  - `address = row_base + (h>>SCALE_SHIFT)`. `row_base` is an incrementally maintained register; the block contains no multiplier.
  - `row_base` clears when `v` wraps to 0.
  - `row_base` increases by `H_ACTIVE>>SCALE_SHIFT` (160) when `h` wraps and the next `v` is a multiple of `2**SCALE_SHIFT` within the active region.
  - Valid addresses are 0..19199. `address` is driven to 0 outside the active region.
- `ram_enable = pixel_enable && active` (combinational from registered counters).
- Output stage: on each `pixel_enable`, the registers load as follows:
  - `{vga_r,vga_g,vga_b}` <= `ram_data` if the delayed-active bit is set, else 0.
  - `hsync`, `vsync` <= their one-stage-delayed values.
- `frame_start` is registered and pulses for exactly one clock.

## Timing
- Reset (async assert, synchronous release): `h=v=0`, `row_base=0`. Outputs are RGB=0, `hsync=vsync=~SYNC_POL`, `ram_enable=0`, `address=0`, `frame_start=0`. The delay-pipeline bits are cleared, so the active bit is 0.
- Latency: the counter state at strobe N produces the BRAM read at that edge. The matching RGB and sync appear on the output registers after strobe N+1, i.e. one pixel period of lag applied uniformly to colour and both syncs.
- Between strobes all outputs hold; `ram_enable` is 0, so the BRAM output holds.
- `pixel_enable` tied high is legal and gives a pixel every clock.
- If reset is asserted mid-frame, the next strobe after release starts at (0,0) with no residual pixel or sync pulse.
- `frame_start` pulses on the clock when RGB for (0,0) is first driven. This is once per frame, every 800*525=420000 strobes.

## Test plan
- Reset then idle with `pixel_enable`=0: all outputs hold their reset values and `ram_enable` stays 0.
- `pixel_enable` every cycle with BRAM model returning `address[11:0]`:
  - hsync low for exactly 96 strobes starting at output strobe 657 of each line.
  - Line period 800 strobes.
- Vsync:
  - low for exactly 2 lines (1600 strobes) starting at line 490.
  - frame period 420000 strobes.
  - `frame_start` exactly once per frame.
- Address sequence:
  - (h,v)=(0,0)->0, (3,0)->0, (4,0)->1, (639,0)->159, (0,3)->0, (0,4)->160, (639,479)->19199.
  - `address`=0 and `ram_enable`=0 throughout blanking.
- `pixel_enable` every 4th clock with random data: RGB equals the data read at the previous strobe, and both syncs share the same one-strobe lag. RGB=0 in every blanking pixel.
- Reset asserted at (h,v)=(300,200): outputs return to reset values immediately. After release, output matches a fresh run from (0,0).

Source files
------------

// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 VGA timing generator and frame-buffer scanout.
// Issues one BRAM read per active pixel (4x pixel-replicated 160x120 image)
// and registers the returned word onto the RGB pins. The syncs go through the
// same two-stage delay as colour so all outputs lag the counters by one strobe.
module vga_scanout #(
    parameter int unsigned H_ACTIVE      = 640,
    parameter int unsigned H_FP          = 16,
    parameter int unsigned H_SYNC        = 96,
    parameter int unsigned H_BP          = 48,
    parameter int unsigned V_ACTIVE      = 480,
    parameter int unsigned V_FP          = 10,
    parameter int unsigned V_SYNC        = 2,
    parameter int unsigned V_BP          = 33,
    parameter int unsigned SCALE_SHIFT   = 2,
    parameter logic        SYNC_POL      = 1'b0,
    parameter int unsigned RAM_ADDR_BITS = 15,
    parameter int unsigned RAM_WIDTH     = 12
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     pixel_enable,
    output logic                     ram_enable,
    output logic [RAM_ADDR_BITS-1:0] address,
    input  logic [RAM_WIDTH-1:0]     ram_data,
    output logic [3:0]               vga_r,
    output logic [3:0]               vga_g,
    output logic [3:0]               vga_b,
    output logic                     hsync,
    output logic                     vsync,
    output logic                     frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_W     = $clog2(H_TOTAL);
    localparam int unsigned V_W     = $clog2(V_TOTAL);

    localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_ACT    = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] HS_START = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_ACT    = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] VS_START = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [V_W-1:0] V_MASK   = V_W'((1 << SCALE_SHIFT) - 1);
    localparam logic [RAM_ADDR_BITS-1:0] ROW_STEP = RAM_ADDR_BITS'(H_ACTIVE >> SCALE_SHIFT);

    logic [H_W-1:0]           h_q, h_d;
    logic [V_W-1:0]           v_q, v_d;
    logic [RAM_ADDR_BITS-1:0] row_base_q, row_base_d;
    logic                     active, hs_raw, vs_raw;
    logic                     act_dly_q, act_dly_d;
    logic                     hs_dly_q, hs_dly_d;
    logic                     vs_dly_q, vs_dly_d;
    logic                     origin_dly_q, origin_dly_d;
    logic [RAM_WIDTH-1:0]     rgb_q, rgb_d;
    logic                     hsync_q, hsync_d;
    logic                     vsync_q, vsync_d;
    logic                     frame_start_q, frame_start_d;

    // Raster counters; row_base steps by one image row every 2**SCALE_SHIFT lines.
    always_comb begin
        h_d        = h_q;
        v_d        = v_q;
        row_base_d = row_base_q;
        if (pixel_enable) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                if (v_q == V_LAST) begin
                    v_d        = '0;
                    row_base_d = '0;
                end else begin
                    v_d = v_q + 1'b1;
                    if ((v_d < V_ACT) && ((v_d & V_MASK) == '0))
                        row_base_d = row_base_q + ROW_STEP;
                end
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    // Decode of the current raster position: active window, raw syncs, BRAM read.
    always_comb begin
        active     = (h_q < H_ACT) && (v_q < V_ACT);
        hs_raw     = ((h_q >= HS_START) && (h_q < HS_END)) ? SYNC_POL : ~SYNC_POL;
        vs_raw     = ((v_q >= VS_START) && (v_q < VS_END)) ? SYNC_POL : ~SYNC_POL;
        ram_enable = pixel_enable && active;
        address    = active ? (row_base_q + RAM_ADDR_BITS'(h_q >> SCALE_SHIFT)) : '0;
    end

    // Delay stage covering the BRAM read, then the output registers.
    always_comb begin
        act_dly_d     = act_dly_q;
        hs_dly_d      = hs_dly_q;
        vs_dly_d      = vs_dly_q;
        origin_dly_d  = origin_dly_q;
        rgb_d         = rgb_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        frame_start_d = pixel_enable && origin_dly_q;
        if (pixel_enable) begin
            act_dly_d    = active;
            hs_dly_d     = hs_raw;
            vs_dly_d     = vs_raw;
            origin_dly_d = (h_q == '0) && (v_q == '0);
            rgb_d        = act_dly_q ? ram_data : '0;
            hsync_d      = hs_dly_q;
            vsync_d      = vs_dly_q;
        end
    end

    // State registers; reset leaves syncs deasserted and the pipeline empty.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            h_q           <= '0;
            v_q           <= '0;
            row_base_q    <= '0;
            act_dly_q     <= 1'b0;
            hs_dly_q      <= ~SYNC_POL;
            vs_dly_q      <= ~SYNC_POL;
            origin_dly_q  <= 1'b0;
            rgb_q         <= '0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            row_base_q    <= row_base_d;
            act_dly_q     <= act_dly_d;
            hs_dly_q      <= hs_dly_d;
            vs_dly_q      <= vs_dly_d;
            origin_dly_q  <= origin_dly_d;
            rgb_q         <= rgb_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga_r       = rgb_q[11:8];
    assign vga_g       = rgb_q[7:4];
    assign vga_b       = rgb_q[3:0];
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout using reduced raster dimensions so several whole
// frames fit in a short run. Driver pushes expectations from a reference
// model; an independent monitor pops and compares on every falling edge.
module tb_vga_scanout;

    localparam int HA = 64, HFP = 8, HSW = 12, HBP = 12;
    localparam int VA = 24, VFP = 3, VSW = 2, VBP = 4;
    localparam int SS = 2;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FRAME = HT * VT;
    localparam logic POL = 1'b0;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        pixel_enable = 1'b0;
    logic        ram_enable;
    logic [14:0] address;
    logic [11:0] ram_data;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        hsync, vsync, frame_start;

    always #5 clock = ~clock;

    vga_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .SCALE_SHIFT(SS), .SYNC_POL(POL),
        .RAM_ADDR_BITS(15), .RAM_WIDTH(12)
    ) dut (
        .clock(clock), .reset_n(reset_n), .pixel_enable(pixel_enable),
        .ram_enable(ram_enable), .address(address), .ram_data(ram_data),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
    );

    // Frame-buffer model: one-cycle read latency, output holds when not enabled.
    logic [11:0] mem [0:255];
    bit          rand_mode = 1'b0;
    always @(posedge clock)
        if (ram_enable) ram_data <= rand_mode ? mem[address[7:0]] : address[11:0];

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct { int due; logic [11:0] rgb; logic hs; logic vs; logic fs; } out_t;
    typedef struct { int due; logic ren; logic [14:0] addr; } adr_t;

    out_t q_out[$];
    adr_t q_adr[$];
    int   idx = 0;
    bit   done = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic int pix_addr(int h, int v);
        return (v >> SS) * (HA >> SS) + (h >> SS);
    endfunction

    function automatic logic [11:0] content(int a);
        return rand_mode ? mem[a] : 12'(a);
    endfunction

    // Expected outputs just after strobe k (k counted from reset): they
    // describe raster position k-1; strobe 0 still shows the reset values.
    function automatic out_t exp_out(int k, int due);
        out_t r;
        int s, h, v;
        r.due = due; r.rgb = '0; r.hs = ~POL; r.vs = ~POL; r.fs = 1'b0;
        if (k > 0) begin
            s = k - 1;
            h = s % HT;
            v = (s / HT) % VT;
            if (h < HA && v < VA) r.rgb = content(pix_addr(h, v));
            if (h >= HA + HFP && h < HA + HFP + HSW) r.hs = POL;
            if (v >= VA + VFP && v < VA + VFP + VSW) r.vs = POL;
            r.fs = (h == 0 && v == 0);
        end
        return r;
    endfunction

    task automatic tick(input bit pe);
        adr_t a;
        int h, v;
        @(posedge clock); #1;
        pixel_enable = pe;
        if (pe) begin
            h = idx % HT;
            v = (idx / HT) % VT;
            a.due  = cyc;
            a.ren  = (h < HA && v < VA);
            a.addr = a.ren ? 15'(pix_addr(h, v)) : '0;
            q_adr.push_back(a);
            q_out.push_back(exp_out(idx, cyc + 1));
            idx++;
        end
    endtask

    task automatic do_reset();
        tick(1'b0);
        @(posedge clock); #1;
        reset_n = 1'b0;
        q_out.push_back(exp_out(0, cyc));
        repeat (3) tick(1'b0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        idx = 0;
    endtask

    // Stimulus
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 12'($urandom);
        do_reset();
        repeat (20) tick(1'b0);
        // strobe every clock, BRAM returns address bits
        repeat (2 * FRAME + 200) tick(1'b1);
        repeat (2) tick(1'b0);
        rand_mode = 1'b1;
        do_reset();
        // strobe every 4th clock, random frame-buffer contents
        repeat (2 * FRAME + 100) begin
            tick(1'b1);
            repeat (3) tick(1'b0);
        end
        // run on to (h,v)=(40,10) and reset mid-frame
        while ((idx % FRAME) != 10 * HT + 40) begin
            tick(1'b1);
            repeat (3) tick(1'b0);
        end
        do_reset();
        repeat (FRAME + 300) begin
            tick(1'b1);
            repeat ($urandom_range(0, 4)) tick(1'b0);
        end
        repeat (3) tick(1'b0);
        done = 1'b1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Monitor
    initial begin
        out_t last;
        out_t r;
        adr_t a;
        bit   have;
        bit   popped;
        have = 1'b0;
        forever begin
            @(negedge clock);
            if (done) begin
                chk("queues_drained", q_out.size() + q_adr.size(), 0);
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
                $finish;
            end
            popped = 1'b0;
            while (q_out.size() > 0 && q_out[0].due <= cyc) begin
                r = q_out.pop_front();
                if (r.due < cyc) chk("out_record_late", r.due, cyc);
                else begin
                    last = r;
                    have = 1'b1;
                    popped = 1'b1;
                end
            end
            if (have) begin
                chk("rgb", {vga_r, vga_g, vga_b}, last.rgb);
                chk("hsync", hsync, last.hs);
                chk("vsync", vsync, last.vs);
                chk("frame_start", frame_start, popped ? last.fs : 1'b0);
                if (!pixel_enable) chk("ram_enable_idle", ram_enable, 1'b0);
            end
            while (q_adr.size() > 0 && q_adr[0].due <= cyc) begin
                a = q_adr.pop_front();
                if (a.due < cyc) chk("adr_record_late", a.due, cyc);
                else begin
                    chk("ram_enable", ram_enable, a.ren);
                    chk("address", address, a.addr);
                end
            end
        end
    end

endmodule
